// File: rtl/rec_mul_pkg.sv
// -----------------------------------------------------------------------------
// rec_mul_pkg
// Shared definitions for the sequential recursive multiplier built around an
// external 2x2 multiplier cell (exact or approximate).
//   state_t  : controller states IDLE -> RUN -> DONE -> IDLE
//   CELL_W   : digit width handed to the 2x2 cell
//   CELL_P_W : width of the product returned by the 2x2 cell
//   digits() : number of 2-bit digits in an operand of a given width
// -----------------------------------------------------------------------------
package rec_mul_pkg;

  localparam int CELL_W   = 2;
  localparam int CELL_P_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digits(input int width);
    return width / CELL_W;
  endfunction

endpackage

// File: rtl/rec_mul_digit_ctr.sv
// -----------------------------------------------------------------------------
// rec_mul_digit_ctr
// Nested (i, j) digit-pair counter. j is the inner index, i the outer one.
// Visits every pair (i, j) in 0..D-1 x 0..D-1 exactly once per operation and
// wraps back to (0, 0) after the last pair.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clr    in   force (i, j) back to (0, 0)
//   i_en     in   advance to the next pair
//   o_i      out  outer digit index (multiplicand digit)
//   o_j      out  inner digit index (multiplier digit)
//   o_last   out  current pair is (D-1, D-1)
//   o_shift  out  weight of the current pair product, 2*(i+j)
// -----------------------------------------------------------------------------
module rec_mul_digit_ctr #(
  parameter int D    = 4,
  parameter int IW   = 2,
  parameter int SH_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [IW-1:0]   o_i,
  output logic [IW-1:0]   o_j,
  output logic            o_last,
  output logic [SH_W-1:0] o_shift
);

  localparam logic [IW-1:0] LAST = IW'(D - 1);

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_en) begin
      if (r_j == LAST) begin
        r_j <= '0;
        // Wrapping i as well leaves the counter at (0, 0) once the sweep ends.
        r_i <= (r_i == LAST) ? '0 : r_i + IW'(1);
      end else begin
        r_j <= r_j + IW'(1);
      end
    end
  end

  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_last  = (r_i == LAST) && (r_j == LAST);
  assign o_shift = SH_W'(2 * (int'(r_i) + int'(r_j)));

endmodule

// File: rtl/rec_mul_seq2.sv
// -----------------------------------------------------------------------------
// rec_mul_seq2
// Sequential recursive multiplier front/back end for an external 2x2 cell.
// Splits the captured operands into 2-bit digits, presents one digit pair per
// RUN cycle on cell_a/cell_b, and accumulates the returned product shifted by
// 2*(i+j) into a 2*WIDTH-bit unsigned result (wrapping on overflow).
// Every pair is visited, including zero digits, since approximate cells may
// return nonzero products for them.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand pair valid
//   in_ready     out  block can accept operands (IDLE only)
//   in_a, in_b   in   WIDTH-bit multiplicand / multiplier
//   cell_a       out  multiplicand digit a[2i+1:2i] to the 2x2 cell
//   cell_b       out  multiplier digit b[2j+1:2j] to the 2x2 cell
//   cell_p       in   4-bit product from the 2x2 cell, same cycle
//   out_valid    out  result valid (DONE)
//   out_ready    in   consumer accepts result
//   out_product  out  2*WIDTH-bit accumulated product, holds the last result
//   busy         out  high in RUN or DONE
// -----------------------------------------------------------------------------
module rec_mul_seq2
  import rec_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic [CELL_W-1:0]     cell_a,
  output logic [CELL_W-1:0]     cell_b,
  input  logic [CELL_P_W-1:0]   cell_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    out_product,
  output logic                  busy
);

  localparam int D    = digits(WIDTH);
  localparam int IW   = (D > 1) ? $clog2(D) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int SH_W = $clog2(PW);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_result;
  logic [PW-1:0]    w_partial;
  logic [PW-1:0]    w_acc_next;

  logic             w_accept;
  logic             w_ctr_en;
  logic             w_last;
  logic [IW-1:0]    w_i;
  logic [IW-1:0]    w_j;
  logic [SH_W-1:0]  w_shift;

  logic [CELL_W-1:0] w_a_dig [D];
  logic [CELL_W-1:0] w_b_dig [D];

  // Digit views of the captured operands; the counter selects one of each.
  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_digit
      assign w_a_dig[gi] = r_a[CELL_W*gi +: CELL_W];
      assign w_b_dig[gi] = r_b[CELL_W*gi +: CELL_W];
    end
  endgenerate

  assign cell_a = w_a_dig[w_i];
  assign cell_b = w_b_dig[w_j];

  rec_mul_digit_ctr #(
    .D    (D),
    .IW   (IW),
    .SH_W (SH_W)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_en    (w_ctr_en),
    .o_i     (w_i),
    .o_j     (w_j),
    .o_last  (w_last),
    .o_shift (w_shift)
  );

  assign w_partial  = PW'(cell_p) << w_shift;
  assign w_acc_next = r_acc + w_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ctr_en     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_ctr_en = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The accumulator is cleared on accept and changes throughout RUN, so the
  // presented result lives in its own register loaded on the final pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_acc <= '0;
    end else if (w_ctr_en) begin
      r_acc <= w_acc_next;
      if (w_last) begin
        r_result <= w_acc_next;
      end
    end
  end

  assign out_product = r_result;

endmodule

// File: tb/tb_rec_mul_seq2.sv
// -----------------------------------------------------------------------------
// tb_rec_mul_seq2
// Bench for rec_mul_seq2 (WIDTH=8) with a behavioural 2x2 cell that can be
// switched between an exact multiplier and the approximate cell
// p = {0, a1&b1, a0&b1 | a1&b0, b0}. Expected products are queued when an
// operand pair is accepted and compared when the result is handed off.
// -----------------------------------------------------------------------------
module tb_rec_mul_seq2;

  localparam int WIDTH = 8;
  localparam int D     = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int LAT   = D * D;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       cell_a;
  logic [1:0]       cell_b;
  logic [3:0]       cell_p;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_product;
  logic             busy;

  logic             approx_mode = 1'b0;
  int               n_chk = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               last_acc_edge = 0;
  logic             prev_ov = 1'b0;
  logic [PW-1:0]    exp_q [$];

  rec_mul_seq2 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .cell_a      (cell_a),
    .cell_b      (cell_b),
    .cell_p      (cell_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] cell_fn(input logic ap, input logic [1:0] a, input logic [1:0] b);
    if (ap) return {1'b0, a[1] & b[1], (a[0] & b[1]) | (a[1] & b[0]), b[0]};
    return {2'b00, a} * {2'b00, b};
  endfunction

  assign cell_p = cell_fn(approx_mode, cell_a, cell_b);

  // Reference: sum of every digit-pair cell product at weight 4^(i+j), mod 2^PW.
  function automatic logic [PW-1:0] model(input logic ap, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        acc += PW'(cell_fn(ap, a[2*i +: 2], b[2*j +: 2])) << (2 * (i + j));
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Result monitor: latency on every rising out_valid, product on handoff.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov)
        chk("latency", 64'(cyc - last_acc_edge), 64'(LAT));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_pending", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          $display("result a-op: product=%0d expected=%0d", out_product, e);
          chk("product", 64'(out_product), 64'(e));
        end
      end
    end
    prev_ov <= out_valid;
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [PW-1:0] e);
    int t;
    t = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      last_acc_edge = cyc + 1;
      exp_q.push_back(e);
      $display("accept a=%0d b=%0d approx=%0d expect=%0d", a, b, approx_mode, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               e1;
    int               t;

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_product",   64'(out_product), 64'd0);
    chk("rst_cell_a",    64'(cell_a), 64'd0);
    chk("rst_cell_b",    64'(cell_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact and approximate corner cases
    approx_mode = 1'b0;
    send(8'd255, 8'd255, 16'd65025);
    in_valid = 1'b0;
    drain();

    approx_mode = 1'b1;
    send(8'd255, 8'd255, 16'd50575);
    in_valid = 1'b0;
    drain();

    send(8'd0, 8'd1, 16'd85);
    in_valid = 1'b0;
    drain();

    approx_mode = 1'b0;
    send(8'd0, 8'd1, 16'd0);
    in_valid = 1'b0;
    drain();

    // Output stall with an ignored operand offer
    approx_mode = 1'b1;
    out_ready = 1'b0;
    send(8'h0D, 8'h02, 16'd26);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", 64'(out_valid), 64'd1);
    in_a = 8'hAA;
    in_b = 8'h55;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_product",  64'(out_product), 64'd26);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("stall_idle_busy", 64'(busy), 64'd0);
    // Digit (0,0) of the still-held operands 0x0D / 0x02.
    chk("stall_no_capture_a", 64'(cell_a), 64'd1);
    chk("stall_no_capture_b", 64'(cell_b), 64'd2);

    // Back-to-back with in_valid and out_ready held high
    approx_mode = 1'b0;
    send(8'd3, 8'd5, 16'd15);
    e1 = last_acc_edge;
    send(8'd200, 8'd100, 16'd20000);
    chk("accept_spacing", 64'(last_acc_edge - e1), 64'(LAT + 2));
    in_valid = 1'b0;
    drain();

    // Random operands against the reference model
    for (int k = 0; k < 4; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      approx_mode = k[0];
      send(ra, rb, model(approx_mode, ra, rb));
      in_valid = 1'b0;
      drain();
    end

    // Reset in the middle of RUN
    approx_mode = 1'b0;
    in_a = 8'd255;
    in_b = 8'd255;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_in_ready",  64'(in_ready), 64'd1);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_busy",      64'(busy), 64'd0);
    chk("async_product",   64'(out_product), 64'd0);
    chk("async_cell_a",    64'(cell_a), 64'd0);
    chk("async_cell_b",    64'(cell_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'd12, 8'd12, 16'd144);
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rec_mul_seq2.md
Name: rec_mul_seq2

Overview:
- Sequential recursive multiplier front/back end for the team's 2x2 multiplier cells (exact or approximate).
- Slices two WIDTH-bit operands into 2-bit digits and presents one digit pair per cycle to an external 2x2 cell.
- Takes the cell's 4-bit product back, shifts it by 2*(i+j) and accumulates it into a 2*WIDTH-bit result.
- Sits directly upstream of the 2x2 cell (feeds its a/b) and directly downstream of it (consumes its product); the choice of cell is made at integration.

Parameters:
- WIDTH, 8, operand width; even, >= 4. D = WIDTH/2 digits per operand.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- cell_a  out  2  digit a[2i+1:2i] to the 2x2 cell.
- cell_b  out  2  digit b[2j+1:2j] to the 2x2 cell.
- cell_p  in  4  2x2 cell product (combinational return, same cycle).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_product  out  2*WIDTH  accumulated product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_product=0, i=j=0, cell_a=cell_b=0, operand registers 0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a/in_b, acc<=0, i<=0, j<=0, go RUN.
- RUN:
  - in_ready=0.
  - cell_a/cell_b are driven combinationally from the captured operands and registers i, j.
  - Each cycle: acc <= acc + (zero-extended cell_p << 2*(i+j)).
  - Then j++. When j==D-1: j<=0, i++.
  - On the cycle with i==D-1 and j==D-1: accumulate, then go DONE.
  - Exactly D*D RUN cycles.
  - No zero-digit skipping: every pair is visited, because approximate cells may return nonzero for a zero digit.
- DONE:
  - out_valid=1, out_product=acc, held stable until out_ready.
  - On out_valid&out_ready: go IDLE.
  - in_ready stays 0 in DONE. A new operand is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises D*D cycles after the accepting edge. Throughput: one op per D*D+2 cycles with out_ready held high.
- Arithmetic: acc is 2*WIDTH bits, unsigned. Any carry beyond 2*WIDTH wraps modulo 2^(2*WIDTH) (defined for arbitrary cells). Exact cells never overflow.
- in_valid during RUN or DONE is ignored: no capture, no state change. The upstream source must hold its data until in_ready.
- out_product outside DONE holds the last result (0 after reset). It is meaningful only when out_valid=1.
- cell_a/cell_b outside RUN hold digit (0,0) of the current operands. They carry no meaning there.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. A partial result is discarded and never presented.

Decomposition:
- Shared package rec_mul_pkg:
  - state enum {IDLE, RUN, DONE};
  - function digits(WIDTH);
  - localparam CELL_W=2, CELL_P_W=4.
- One natural sub-module: rec_mul_digit_ctr, the (i, j) nested counter with a last_pair flag and shift amount 2*(i+j).
- The 2x2 cell is not instantiated inside this block. The bench and integration wrapper bind it to cell_a/cell_b/cell_p.

Test Plan:
- Exact cell, WIDTH=8: a=255, b=255 -> out_product=65025, out_valid exactly 16 cycles after accept.
- Approximate cell p={0, a1&b1, a0&b1|a1&b0, b0}, a=255, b=255: every pair returns 7 -> out_product=7*85*85=50575.
- Approximate cell (same as above), a=0, b=1: the a-digit 00 / b-digit 01 pair returns 1 for all i -> out_product=1+4+16+64=85, confirming no zero-skip. Exact cell gives 0.
- Approximate cell (same as above), a=0x0D, b=0x02 -> out_product=26. out_ready held low 5 cycles: out_valid and out_product stay stable, in_ready stays 0, and an asserted in_valid is ignored.
- Back-to-back, out_ready=1, in_valid=1 continuously, exact cell: results 3*5=15 then 200*100=20000. Accepts are spaced 18 cycles apart.
- Reset: rst_n pulsed low at RUN cycle 7 of a=255, b=255 -> all outputs return to reset values asynchronously. The next op, 12*12 exact, returns 144.
